// File: rtl/f_predict_if.sv
// Fetch-side BTB bus: lookup PC, execute-stage write port and prediction results.
interface f_predict_if;
  logic [12:0] pc;
  logic        stall;
  logic        flush;
  logic [15:0] w_data;
  logic [10:0] w_addr;
  logic        wen;
  logic [12:0] pc_predicted;
  logic        hit;
  logic        ready;

  modport master (
    output pc, stall, flush, w_data, w_addr, wen,
    input  pc_predicted, hit, ready
  );

  modport slave (
    input  pc, stall, flush, w_data, w_addr, wen,
    output pc_predicted, hit, ready
  );
endinterface

// File: rtl/f_predict.sv
// Branch target buffer: 2048-entry target table with an invalidation sweep after reset/flush.
// Optional write-first lookup forwarding is enabled by defining F_PREDICT_BYPASS_EN.
module f_predict (
  input  logic        clk,
  input  logic        rst_n,
  f_predict_if.slave  bus
);
  localparam int unsigned ENTRIES   = 2048;
  localparam int unsigned IDX_W     = 11;
  localparam int unsigned PC_W      = 13;
  localparam int unsigned ENT_W     = 16;
  localparam int unsigned VALID_BIT = 15;
  localparam int unsigned TAG_HI    = 14;
  localparam int unsigned TAG_LO    = 13;
  localparam int unsigned TGT_HI    = 12;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [ENT_W-1:0]   ent_q, ent_d;

  logic [ENT_W-1:0]   table_mem [ENTRIES];

  logic               run_wr_c;
  logic               mem_we_c;
  logic [IDX_W-1:0]   mem_addr_c;
  logic [ENT_W-1:0]   mem_wdata_c;
  logic [IDX_W-1:0]   rd_idx_c;

  // Sweep state machine and the single table write port it shares with execute.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_wr_c    = (state_q == RUN) && bus.wen && !bus.flush;
    mem_we_c    = 1'b0;
    mem_addr_c  = bus.w_addr;
    mem_wdata_c = bus.w_data;

    case (state_q)
      CLEAR: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = cnt_q;
        mem_wdata_c = '0;
        cnt_d       = cnt_q + IDX_W'(1);
        if (bus.flush) begin
          cnt_d = '0;
        end else if (cnt_q == IDX_W'(ENTRIES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        mem_we_c = run_wr_c;
        if (bus.flush) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Lookup pipeline register; holds while fetch is stalled.
  always_comb begin
    rd_idx_c = bus.pc[IDX_W-1:0];
    pc_d     = pc_q;
    ent_d    = ent_q;
    if (!bus.stall) begin
      pc_d  = bus.pc;
      ent_d = table_mem[rd_idx_c];
`ifdef F_PREDICT_BYPASS_EN
      if (run_wr_c && (bus.w_addr == rd_idx_c)) begin
        ent_d = bus.w_data;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      pc_q    <= '0;
      ent_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ent_q   <= ent_d;
    end
  end

  // Table contents are not reset; the sweep clears them.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      table_mem[mem_addr_c] <= mem_wdata_c;
    end
  end

  assign bus.ready        = (state_q == RUN);
  assign bus.hit          = bus.ready && ent_q[VALID_BIT] && (ent_q[TAG_HI:TAG_LO] == pc_q[PC_W-1:IDX_W]);
  assign bus.pc_predicted = bus.hit ? ent_q[TGT_HI:0] : pc_q + PC_W'(1);

endmodule

// File: tb/tb_f_predict.sv
// Self-checking bench for f_predict: vector table plus sweep/flush/reset sequences.
module tb_f_predict;
`ifdef F_PREDICT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  f_predict_if bus ();

  f_predict dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [12:0] pc;
    logic        stall;
    logic        flush;
    logic        wen;
    logic [10:0] w_addr;
    logic [15:0] w_data;
    logic        exp_hit;
    logic [12:0] exp_pred;
    logic        exp_ready;
  } vec_t;

  typedef struct {
    string       name;
    logic        h;
    logic [12:0] p;
    logic        r;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string nm, logic [12:0] pc, logic st, logic fl, logic we,
                              logic [10:0] wa, logic [15:0] wd,
                              logic eh, logic [12:0] ep, logic er);
    vec_t v;
    v.name = nm; v.pc = pc; v.stall = st; v.flush = fl; v.wen = we;
    v.w_addr = wa; v.w_data = wd; v.exp_hit = eh; v.exp_pred = ep; v.exp_ready = er;
    return v;
  endfunction

  task automatic push_exp(string nm, logic h, logic [12:0] p, logic r);
    exp_t e;
    e.name = nm; e.h = h; e.p = p; e.r = r;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: output observed with no expected entry queued");
      return;
    end
    e = sb.pop_front();
    if (bus.hit !== e.h || bus.pc_predicted !== e.p || bus.ready !== e.r) begin
      errors++;
      $display("FAIL %s: got hit=%0b pred=%h ready=%0b, expected hit=%0b pred=%h ready=%0b",
               e.name, bus.hit, bus.pc_predicted, bus.ready, e.h, e.p, e.r);
    end
  endtask

  task automatic check_val(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.pc = v.pc; bus.stall = v.stall; bus.flush = v.flush;
    bus.wen = v.wen; bus.w_addr = v.w_addr; bus.w_data = v.w_data;
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.flush = 1'b0; bus.wen = 1'b0;
    bus.w_addr = '0; bus.w_data = '0;
  endtask

  task automatic step(vec_t v);
    drive(v);
    push_exp(v.name, v.exp_hit, v.exp_pred, v.exp_ready);
    @(posedge clk);
    #1;
    check_front();
  endtask

  // Counts edges until ready; ready and hit must stay low throughout.
  task automatic wait_ready(string nm, int exp_n);
    int   n;
    logic bad_hit;
    n = 0;
    bad_hit = 1'b0;
    while (!bus.ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.ready && bus.hit) bad_hit = 1'b1;
    end
    check_val({nm, "_cycles"}, n, exp_n);
    check_val({nm, "_hit_during_sweep"}, int'(bad_hit), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.pc = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    push_exp("reset_values", 1'b0, 13'h0001, 1'b0);
    check_front();

    rst_n = 1'b1;
    wait_ready("initial_sweep", 2048);

    vecs.push_back(mk("miss_seq",      13'h0005, 0, 0, 0, 11'h000, 16'h0000, 0, 13'h0006, 1));
    vecs.push_back(mk("write_a123",    13'h0000, 0, 0, 1, 11'h010, 16'hA123, 0, 13'h0001, 1));
    vecs.push_back(mk("hit_0810",      13'h0810, 0, 0, 0, 11'h000, 16'h0000, 1, 13'h0123, 1));
    vecs.push_back(mk("tag_miss_0010", 13'h0010, 0, 0, 0, 11'h000, 16'h0000, 0, 13'h0011, 1));
    vecs.push_back(mk("wrap_1fff",     13'h1FFF, 0, 0, 0, 11'h000, 16'h0000, 0, 13'h0000, 1));
    vecs.push_back(mk("same_cyc_wr",   13'h0820, 0, 0, 1, 11'h020, 16'hA456, BYP,
                      BYP ? 13'h0456 : 13'h0821, 1));
    vecs.push_back(mk("after_wr_0820", 13'h0820, 0, 0, 0, 11'h000, 16'h0000, 1, 13'h0456, 1));
    vecs.push_back(mk("pre_stall",     13'h0810, 0, 0, 0, 11'h000, 16'h0000, 1, 13'h0123, 1));
    vecs.push_back(mk("stall_hold1",   13'h0004, 1, 0, 0, 11'h000, 16'h0000, 1, 13'h0123, 1));
    vecs.push_back(mk("stall_hold2",   13'h0004, 1, 0, 0, 11'h000, 16'h0000, 1, 13'h0123, 1));
    vecs.push_back(mk("unstall_0004",  13'h0004, 0, 0, 0, 11'h000, 16'h0000, 0, 13'h0005, 1));
    vecs.push_back(mk("stall_write",   13'h0830, 1, 0, 1, 11'h030, 16'hA789, 0, 13'h0005, 1));
    vecs.push_back(mk("hit_0830",      13'h0830, 0, 0, 0, 11'h000, 16'h0000, 1, 13'h0789, 1));
    vecs.push_back(mk("tag11_miss",    13'h1810, 0, 0, 0, 11'h000, 16'h0000, 0, 13'h1811, 1));
    vecs.push_back(mk("write_invalid", 13'h0000, 0, 0, 1, 11'h040, 16'h2222, 0, 13'h0001, 1));
    vecs.push_back(mk("invalid_miss",  13'h0840, 0, 0, 0, 11'h000, 16'h0000, 0, 13'h0841, 1));
    vecs.push_back(mk("flush_drop_wr", 13'h0810, 0, 1, 1, 11'h050, 16'hA555, 0, 13'h0811, 0));

    foreach (vecs[i]) step(vecs[i]);

    // Writes attempted during the sweep must be ignored.
    bus.flush = 1'b0;
    bus.wen = 1'b1; bus.w_addr = 11'h010; bus.w_data = 16'hA123;
    wait_ready("flush_sweep", 2048);
    idle_inputs();
    step(mk("post_flush_0810", 13'h0810, 0, 0, 0, 11'h000, 16'h0000, 0, 13'h0811, 1));
    step(mk("post_flush_0850", 13'h0850, 0, 0, 0, 11'h000, 16'h0000, 0, 13'h0851, 1));
    step(mk("post_flush_0830", 13'h0830, 0, 0, 0, 11'h000, 16'h0000, 0, 13'h0831, 1));
    step(mk("post_flush_wrap", 13'h1FFF, 0, 0, 0, 11'h000, 16'h0000, 0, 13'h0000, 1));

    // Flush in the middle of a sweep restarts it from index 0.
    step(mk("flush_a",         13'h0002, 0, 1, 0, 11'h000, 16'h0000, 0, 13'h0003, 0));
    idle_inputs();
    repeat (100) @(posedge clk);
    #1;
    step(mk("flush_restart",   13'h0002, 0, 1, 0, 11'h000, 16'h0000, 0, 13'h0003, 0));
    idle_inputs();
    wait_ready("restart_sweep", 2048);

    // Reset asserted at sweep count 500.
    step(mk("flush_b",         13'h0810, 0, 1, 0, 11'h000, 16'h0000, 0, 13'h0811, 0));
    idle_inputs();
    repeat (500) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    push_exp("mid_sweep_reset", 1'b0, 13'h0001, 1'b0);
    check_front();
    #2;
    rst_n = 1'b1;
    wait_ready("reset_sweep", 2048);
    step(mk("final_wrap",      13'h1FFF, 0, 0, 0, 11'h000, 16'h0000, 0, 13'h0000, 1));

    check_val("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/f_predict.md
# f_predict

Fetch-side branch target buffer (BTB). It stores the jump targets that the execute stage writes through its `w_data`/`w_addr`/`wen` port. For each fetch PC it returns `pc_predicted`, the predicted next PC that the execute stage later checks against the resolved next PC. It sits between the fetch PC register and the instruction-memory address mux. It owns a 2048-entry table and a sweep state machine that invalidates every entry after reset or flush.

## Interface
- `ENTRIES`, 2048: table depth; index is `pc[10:0]`.
- `clk  in  1`: single clock; all state updates on rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `pc  in  13`: current fetch PC (word address).
- `stall  in  1`: fetch stall; holds lookup registers.
- `flush  in  1`: one-cycle pulse; invalidates the whole table.
- `w_data  in  16`: write entry `{valid, tag[1:0], target[12:0]}`.
- `w_addr  in  11`: write index.
- `wen  in  1`: write enable.
- `pc_predicted  out  13`: predicted next PC for the registered PC.
- `hit  out  1`: registered PC hit a valid entry with a matching tag.
- `ready  out  1`: table usable; 0 during the invalidation sweep.

## Operation
- Entry format: bit15 valid, bits14:13 tag (`pc[12:11]`), bits12:0 target.
- Lookup: at each rising edge with `stall`=0, the block latches `pc` into `pc_q` and latches `table[pc[10:0]]` into `ent_q`. With `stall`=1, `pc_q` and `ent_q` hold.
- `hit = ready & ent_q[15] & (ent_q[14:13] == pc_q[12:11])`.
- `pc_predicted = hit ? ent_q[12:0] : pc_q + 1`. The result is a 13-bit add; 13'h1FFF+1 wraps to 0.
- Writes: when `wen`=1 and state is RUN, `table[w_addr] <= w_data` at the edge. Writes proceed regardless of `stall`.
- State machine:
  - State CLEAR: each cycle writes 16'h0000 to `table[cnt]` and increments the 11-bit `cnt`.
  - When `cnt`=2047 is written, the next state is RUN.
  - While in CLEAR, `wen` is ignored and `ready`=0.
  - State RUN: `ready`=1. `flush`=1 causes next state CLEAR with `cnt`=0. In that flush cycle, a concurrent `wen` is dropped.
  - `flush`=1 while already in CLEAR restarts the sweep with `cnt`=0.
- While `ready`=0, `hit` is 0, so `pc_predicted` is `pc_q+1` (sequential fetch).
- Same-cycle read/write to the same index: without the bypass, the lookup returns the old entry. With the bypass, see Configuration.

## Timing
- Reset (async assert) values:
  - state=CLEAR, `cnt`=0, `pc_q`=0, `ent_q`=0.
  - Outputs: `hit`=0, `pc_predicted`=13'd1, `ready`=0.
- Table contents are not reset; the sweep clears them.
- After `rst_n` deassertion, the sweep takes exactly 2048 cycles. `ready` rises on the edge after the `cnt`=2047 write.
- Lookup latency is 1 cycle: `pc` presented before edge N gives `hit`/`pc_predicted` after edge N. Both outputs are combinational from `pc_q`/`ent_q`/state.
- A write at edge N is visible to a lookup of the same index latched at edge N+1 or later.
- `flush` latency: `ready` falls after the flush edge. Entries written before the flush are gone once the sweep passes their index. `hit` is forced to 0 from the flush edge onward.
- Asserting `rst_n` mid-sweep or mid-run returns the block immediately to the reset values above.

## Configuration
- `F_PREDICT_BYPASS_EN`:
  - Defined: when `wen`=1 and state is RUN with `w_addr == pc[10:0]` at a non-stalled edge, `ent_q` latches `w_data` instead of the old table entry (write-first forwarding).
  - Undefined: `ent_q` latches the old entry (read-first), and the new entry is visible from the next lookup.

## Test plan
- Reset then idle: for 2048 cycles `ready`=0. Cycle 2048 `ready`=1. With `pc`=13'h0005 → `hit`=0, `pc_predicted`=13'h0006.
- Write `w_addr`=11'h010, `w_data`=16'hA123 (valid, tag 01, target 13'h0123). Then lookup `pc`=13'h0810 → `hit`=1, `pc_predicted`=13'h0123. Lookup `pc`=13'h0010 (tag 00) → `hit`=0, `pc_predicted`=13'h0011.
- Same-cycle write 16'hA123 at index 11'h010 with `pc`=13'h0810 → with the bypass, `hit`=1 and target 13'h0123 next cycle. Without it, `hit`=0 and `pc_predicted`=13'h0811.
- `stall`=1 while `pc` changes from 13'h0810 to 13'h0004 → `pc_predicted` stays 13'h0123 until `stall`=0.
- `flush` pulse after the entry above → `ready`=0 for 2048 cycles and `wen` writes are ignored. Afterwards, `pc`=13'h0810 → `hit`=0. Wrap check: `pc`=13'h1FFF on a miss → `pc_predicted`=13'h0000.
- `rst_n` pulsed low at sweep `cnt`=500 → outputs return to reset values immediately. A full 2048-cycle sweep follows before `ready`=1.
